// File: rtl/tutorial_aula_cpu_debug_mon_access.sv
// Debug monitor RAM shared by JTAG (priority) and CPU; CPU reads return 1 cycle after acceptance.
// Backpressure: cpu_waitrequest holds the CPU off while JTAG owns the RAM (JRD/JWR); strobes outside IDLE are dropped.
module tutorial_aula_cpu_debug_mon_access #(
  parameter int MON_AW         = 8,
  parameter int ERR_ON_OVERRUN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [MON_AW-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int DEPTH = 1 << MON_AW;

  typedef enum logic [1:0] {IDLE, JRD, JCAP, JWR} state_t;

  state_t            state, state_nxt;
  logic [MON_AW-1:0] MonAReg;
  logic [31:0]       wdata_q;
  logic [31:0]       ram_q;
  logic [31:0]       mem [DEPTH];

  logic              jtag_owns;
  logic              cpu_acc_wr, cpu_acc_rd;
  logic [MON_AW-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wd;
  logic              any_strobe, multi_strobe;
  logic              err_set, err_clr;
  logic              do_load, do_wlat, do_inc, do_cap;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jtag_owns       = (state == JRD) || (state == JWR);
  assign cpu_waitrequest = jtag_owns;
  assign monitor_ready   = (state == IDLE);

  // Read and write together is a write.
  assign cpu_acc_wr = cpu_write & ~jtag_owns;
  assign cpu_acc_rd = cpu_read & ~cpu_write & ~jtag_owns;

  assign ram_addr = jtag_owns ? MonAReg : cpu_address;
  assign ram_we   = (state == JWR) ? 4'hF : (cpu_acc_wr ? cpu_byteenable : 4'h0);
  assign ram_wd   = (state == JWR) ? wdata_q : cpu_writedata;

  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);
  assign err_set = (ERR_ON_OVERRUN != 0) &&
                   (((state != IDLE) && any_strobe) || ((state == IDLE) && multi_strobe));
  assign err_clr = (state == IDLE) && take_action_ocimem_a && jdo[24];

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_wlat   = 1'b0;
    do_inc    = 1'b0;
    do_cap    = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          do_load = 1'b1;
          if (jdo[25]) state_nxt = JRD;
        end else if (take_action_ocimem_b) begin
          do_wlat   = 1'b1;
          state_nxt = JWR;
        end else if (take_no_action_ocimem_a) begin
          state_nxt = JRD;
        end
      end
      JRD:  state_nxt = JCAP;
      JCAP: begin
        do_cap    = 1'b1;
        do_inc    = 1'b1;
        state_nxt = IDLE;
      end
      JWR: begin
        do_inc    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM array: no reset, byte-lane writes, registered read returns old data on collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ram_q <= '0;
    else       ram_q <= mem[ram_addr];
  end

  assign cpu_readdata = ram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      MonAReg           <= '0;
      MonDReg           <= '0;
      wdata_q           <= '0;
      monitor_error     <= 1'b0;
      cpu_readdatavalid <= 1'b0;
    end else begin
      state             <= state_nxt;
      cpu_readdatavalid <= cpu_acc_rd;
      if (do_load)     MonAReg <= jdo[35 -: MON_AW];
      else if (do_inc) MonAReg <= MonAReg + MON_AW'(1);
      if (do_wlat) wdata_q <= jdo[34:3];
      if (do_cap)  MonDReg <= ram_q;
      // A same-cycle overrun outranks the clear request.
      if (err_set)      monitor_error <= 1'b1;
      else if (err_clr) monitor_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tutorial_aula_cpu_debug_mon_access.sv
// Bench for the debug monitor: CPU byte-lane vectors from a table, JTAG and arbitration sequences by hand.
// CPU read data is checked through an expected-value queue popped whenever cpu_readdatavalid is seen.
module tb_tutorial_aula_cpu_debug_mon_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb_q [$];

  tutorial_aula_cpu_debug_mon_access #(.MON_AW(8), .ERR_ON_OVERRUN(1)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_waitrequest         (cpu_waitrequest),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cpu_readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected_valid: got data 0x%08h, expected no read", cpu_readdata);
      end else begin
        check("sb_readdata", cpu_readdata, sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8 && monitor_ready !== 1'b1; i++) step();
    check("ready_timeout", {31'b0, monitor_ready}, 32'd1);
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic rd, input logic clr);
    jdo = '0;
    jdo[35:28] = addr;
    jdo[25] = rd;
    jdo[24] = clr;
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    cpu_address = addr;
    cpu_writedata = data;
    cpu_byteenable = be;
    cpu_write = 1'b1;
    step();
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] addr, input logic [31:0] exp);
    cpu_address = addr;
    cpu_read = 1'b1;
    sb_q.push_back(exp);
    step();
    cpu_read = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] init;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lowcnt;
    vecs[0] = '{8'h60, 32'h11223344, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    vecs[1] = '{8'h61, 32'h11223344, 32'hAABBCCDD, 4'b1010, 32'hAA22CC44};
    vecs[2] = '{8'h62, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 32'hFF000000};
    vecs[3] = '{8'h63, 32'h89ABCDEF, 32'h01234567, 4'b1111, 32'h01234567};
    vecs[4] = '{8'h64, 32'h5A5A5A5A, 32'hFFFFFFFF, 4'b0000, 32'h5A5A5A5A};

    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;
    step();
    step();
    check("rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("rst_error", {31'b0, monitor_error}, 32'd0);
    check("rst_mondreg", MonDReg, 32'd0);
    check("rst_valid", {31'b0, cpu_readdatavalid}, 32'd0);
    check("rst_readdata", cpu_readdata, 32'd0);
    check("rst_wait", {31'b0, cpu_waitrequest}, 32'd0);
    reset = 1'b0;
    step();

    // CPU byte-lane vectors
    for (int i = 0; i < 5; i++) begin
      cpu_wr(vecs[i].addr, vecs[i].init, 4'hF);
      cpu_wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      cpu_rd(vecs[i].addr, vecs[i].exp);
    end
    step();

    // JTAG write then read back at 0x10
    jtag_a(8'h10, 1'b0, 1'b0);
    check("load_only_ready", {31'b0, monitor_ready}, 32'd1);
    jtag_b(32'hDEADBEEF);
    check("jwr_ready_low", {31'b0, monitor_ready}, 32'd0);
    step();
    check("jwr_areg", {24'b0, dut.MonAReg}, 32'h11);
    jtag_a(8'h10, 1'b1, 1'b0);
    lowcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (monitor_ready !== 1'b1) lowcnt++;
      step();
    end
    check("jrd_ready_low_cycles", lowcnt, 32'd2);
    check("jrd_mondreg", MonDReg, 32'hDEADBEEF);
    check("jrd_areg", {24'b0, dut.MonAReg}, 32'h11);
    cpu_rd(8'h10, 32'hDEADBEEF);

    // Address wrap
    jtag_a(8'hFF, 1'b0, 1'b0);
    jtag_b(32'h1);
    step();
    jtag_b(32'h2);
    step();
    check("wrap_areg", {24'b0, dut.MonAReg}, 32'h01);
    cpu_rd(8'hFF, 32'h1);
    cpu_rd(8'h00, 32'h2);
    jtag_a(8'hFF, 1'b1, 1'b0);
    wait_idle();
    check("wrap_jtag_read", MonDReg, 32'h1);

    // Arbitration: CPU read held at 0x20 across a JTAG write
    cpu_wr(8'h20, 32'h12345678, 4'hF);
    jtag_a(8'h20, 1'b0, 1'b0);
    cpu_address = 8'h20;
    cpu_read = 1'b1;
    jdo = '0;
    jdo[34:3] = 32'hCAFEF00D;
    take_action_ocimem_b = 1'b1;
    check("arb_wait_c0", {31'b0, cpu_waitrequest}, 32'd0);
    sb_q.push_back(32'h12345678);
    step();
    take_action_ocimem_b = 1'b0;
    check("arb_wait_c1", {31'b0, cpu_waitrequest}, 32'd1);
    step();
    check("arb_wait_c2", {31'b0, cpu_waitrequest}, 32'd0);
    sb_q.push_back(32'hCAFEF00D);
    step();
    cpu_read = 1'b0;
    step();

    // Overrun: read-next strobe held two cycles
    jtag_a(8'h30, 1'b0, 1'b1);
    cpu_wr(8'h30, 32'h0BADF00D, 4'hF);
    take_no_action_ocimem_a = 1'b1;
    step();
    step();
    take_no_action_ocimem_a = 1'b0;
    wait_idle();
    check("ovr_error_set", {31'b0, monitor_error}, 32'd1);
    check("ovr_one_read_areg", {24'b0, dut.MonAReg}, 32'h31);
    check("ovr_mondreg", MonDReg, 32'h0BADF00D);
    jtag_a(8'h40, 1'b0, 1'b0);
    check("ovr_error_sticky", {31'b0, monitor_error}, 32'd1);
    jtag_a(8'h40, 1'b0, 1'b1);
    check("ovr_error_clr", {31'b0, monitor_error}, 32'd0);

    // Same-cycle strobes: a beats b
    jdo = '0;
    jdo[35:28] = 8'h55;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    check("pri_ab_ready", {31'b0, monitor_ready}, 32'd1);
    check("pri_ab_areg", {24'b0, dut.MonAReg}, 32'h55);
    check("pri_ab_error", {31'b0, monitor_error}, 32'd1);
    // Clear and set in one cycle: set wins
    jdo = '0;
    jdo[35:28] = 8'h56;
    jdo[24] = 1'b1;
    take_action_ocimem_a = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    check("pri_an_error", {31'b0, monitor_error}, 32'd1);
    check("pri_an_areg", {24'b0, dut.MonAReg}, 32'h56);
    jtag_a(8'h56, 1'b0, 1'b1);
    check("pri_clear", {31'b0, monitor_error}, 32'd0);
    // b beats read-next
    jdo = '0;
    jdo[34:3] = 32'h13572468;
    take_action_ocimem_b = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    check("pri_bn_busy", {31'b0, monitor_ready}, 32'd0);
    check("pri_bn_error", {31'b0, monitor_error}, 32'd1);
    wait_idle();
    cpu_rd(8'h56, 32'h13572468);
    step();

    // Reset asserted mid-read
    jtag_a(8'h10, 1'b1, 1'b0);
    check("mid_in_jrd", {31'b0, monitor_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("mid_rst_mondreg", MonDReg, 32'd0);
    check("mid_rst_areg", {24'b0, dut.MonAReg}, 32'd0);
    check("mid_rst_error", {31'b0, monitor_error}, 32'd0);
    step();
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    check("rst_strobe_ignored", {31'b0, monitor_ready}, 32'd1);
    reset = 1'b0;
    step();
    check("post_rst_ready", {31'b0, monitor_ready}, 32'd1);
    check("post_rst_areg", {24'b0, dut.MonAReg}, 32'd0);

    step();
    step();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tutorial_aula_cpu_debug_mon_access.md
TUTORIAL_AULA_CPU_DEBUG_MON_ACCESS -- requirements
Module: tutorial_aula_cpu_debug_mon_access

Interface
REQ-001 SHALL have parameter MON_AW, default 8, monitor RAM address width (depth 2^MON_AW words of 32 bits).
REQ-002 SHALL have parameter ERR_ON_OVERRUN, default 1; 1 enables the monitor_error overrun flag, 0 forces it to 0.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, in that order:
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
REQ-004 SHALL have the following other ports:
- jdo  in  38  JTAG debug data, already synchronised into clk
- take_action_ocimem_a  in  1  one-cycle strobe: command/address load
- take_action_ocimem_b  in  1  one-cycle strobe: JTAG write of jdo[34:3]
- take_no_action_ocimem_a  in  1  one-cycle strobe: JTAG read-next
- cpu_address  in  MON_AW  CPU word address
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- cpu_writedata  in  32  CPU write data
- cpu_byteenable  in  4  CPU byte lanes
- cpu_waitrequest  out  1  CPU access not accepted this cycle
- cpu_readdata  out  32  CPU read data
- cpu_readdatavalid  out  1  cpu_readdata valid
- MonDReg  out  32  JTAG monitor data register
- monitor_ready  out  1  no JTAG operation pending
- monitor_error  out  1  sticky JTAG overrun flag

Function
REQ-005 SHALL contain a single-port 2^MON_AW x 32 RAM with synchronous read (1-cycle latency); contents are not reset.
REQ-006 SHALL hold a MON_AW-bit address register MonAReg.
REQ-007 SHALL implement states IDLE, JRD, JCAP, JWR.
REQ-008 take_action_ocimem_a in IDLE: MonAReg <= jdo[35:36-MON_AW]; if jdo[25]=1, go to JRD, else stay in IDLE; if jdo[24]=1, clear monitor_error.
REQ-009 take_action_ocimem_b in IDLE: latch jdo[34:3], go to JWR.
REQ-010 take_no_action_ocimem_a in IDLE: go to JRD.
REQ-011 JRD: present MonAReg to the RAM, then go to JCAP.
REQ-012 JCAP: MonDReg <= RAM output; MonAReg <= MonAReg+1; go to IDLE.
REQ-013 JWR: write the latched data to all 4 byte lanes at MonAReg; MonAReg <= MonAReg+1; go to IDLE.
REQ-014 MonAReg increment SHALL wrap from 2^MON_AW-1 to 0.
REQ-015 monitor_ready SHALL be 1 only in IDLE.
- Goes low in the cycle after an accepted strobe.
- Returns high in the cycle after JCAP or JWR.
REQ-016 Strobe arriving while not in IDLE:
- Ignored; no state, address or data change.
- Sets monitor_error when ERR_ON_OVERRUN=1.
REQ-017 Two or more strobes in the same IDLE cycle:
- Priority take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a; only the highest is acted on.
- Lower strobes dropped; sets monitor_error when ERR_ON_OVERRUN=1.
- jdo[24] clear and a same-cycle set: set wins.
REQ-018 JTAG has RAM priority. cpu_waitrequest = 1 in JRD and JWR, else 0 (combinational from state only).
REQ-019 CPU access is accepted when cpu_read or cpu_write is high and cpu_waitrequest=0.
REQ-020 Accepted cpu_write: writes the bytes selected by cpu_byteenable at cpu_address.
REQ-021 Accepted cpu_read: cpu_readdatavalid=1 and cpu_readdata valid exactly one cycle later; cpu_readdatavalid=0 otherwise.
REQ-022 cpu_read and cpu_write both high SHALL be treated as a write.
REQ-023 A JTAG strobe and a CPU access in the same IDLE cycle: the CPU access completes that cycle; the JTAG operation occupies the RAM from the next cycle.
REQ-024 Read-during-write to the same address SHALL return old data.

Reset
REQ-025 On reset assertion, asynchronously:
- state = IDLE, MonAReg = 0, MonDReg = 0, latched write data = 0
- monitor_ready = 1, monitor_error = 0
- cpu_readdatavalid = 0, cpu_readdata = 0
REQ-026 Reset during JRD/JCAP/JWR SHALL abort the operation. A write in JWR coincident with the reset edge may or may not complete; the bench SHALL not check that word.
REQ-027 Strobes SHALL be ignored while reset is high.

Verification
REQ-028 JTAG write/read:
- Stimulus: ocimem_a with jdo address 0x10, jdo[25]=0; ocimem_b with data 0xDEADBEEF; ocimem_a address 0x10, jdo[25]=1.
- Response: MonDReg=0xDEADBEEF; MonAReg=0x11; monitor_ready low exactly 2 cycles during the read.
REQ-029 Wrap:
- Stimulus: load address 0xFF; JTAG write 0x1; JTAG write 0x2.
- Response: words 0xFF=0x1 and 0x00=0x2; MonAReg=0x01.
REQ-030 Arbitration:
- Stimulus: cpu_read at 0x20 held continuously; JTAG write to 0x20 issued.
- Response: cpu_waitrequest high exactly 1 cycle; later cpu_readdata reflects the new value one cycle after acceptance.
REQ-031 Overrun:
- Stimulus: take_no_action_ocimem_a in two consecutive cycles.
- Response: one read performed; monitor_error=1 until an ocimem_a with jdo[24]=1, then 0.
REQ-032 Byte enables:
- Stimulus: CPU write 0xAABBCCDD with byteenable 4'b0101 over existing 0x11223344.
- Response: read back 0x11BB33DD.
REQ-033 Reset mid-read:
- Stimulus: assert reset in JRD.
- Response: monitor_ready=1, MonDReg=0, MonAReg=0 immediately, without a clock edge.
